// File: rtl/dmem_responder.sv
// Word-addressed data memory responder: WAIT_STATES access latency, one-cycle response pulse.
// Optional one-entry posted write buffer enabled by defining DMEM_WBUF_EN.
module dmem_responder #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    output logic              rsp_is_write_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              stall_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Last ACCESS count value; unused when WAIT_STATES is 0 because ACCESS is skipped.
    localparam logic [2:0] LAST_CNT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_is_write_q, rsp_is_write_d;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic              req_ready;
    logic              fsm_accept;
    logic              fsm_wr;
    logic              fsm_rd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

`ifdef DMEM_WBUF_EN
    localparam logic [2:0] DRAIN_CNT = 3'(WAIT_STATES);

    logic              wbuf_valid_q;
    logic [2:0]        wbuf_cnt_q;
    logic [ADDR_W-1:0] wbuf_addr_q;
    logic [DATA_W-1:0] wbuf_data_q;
    logic              wbuf_hit;
    logic              wbuf_push;
    logic              wbuf_drain;
    logic              fwd_rd;
`endif

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_is_write_q <= 1'b0;
            rsp_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_is_write_q <= rsp_is_write_d;
            if (fsm_accept) begin
                addr_q  <= req_addr_i;
                we_q    <= req_we_i;
                wdata_q <= req_wdata_i;
            end
            if (fsm_rd) begin
                rsp_rdata_q <= mem[addr_q];
            end
`ifdef DMEM_WBUF_EN
            else if (fwd_rd) begin
                rsp_rdata_q <= wbuf_data_q;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (fsm_accept) begin
                    cnt_d   = 3'd0;
                    state_d = (WAIT_STATES == 0) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == IDLE);
        fsm_accept     = req_valid_i & req_ready;
        fsm_wr         = (state_q == RESP) & we_q;
        fsm_rd         = (state_q == RESP) & ~we_q;
        ram_we         = fsm_wr;
        ram_waddr      = addr_q;
        ram_wdata      = wdata_q;
        rsp_valid_d    = fsm_wr | fsm_rd;
        rsp_is_write_d = fsm_wr ? 1'b1 : (fsm_rd ? 1'b0 : rsp_is_write_q);
`ifdef DMEM_WBUF_EN
        // Stores always go to the buffer, so the FSM only ever carries loads here.
        wbuf_hit   = wbuf_valid_q & ~req_we_i & (req_addr_i == wbuf_addr_q);
        wbuf_drain = wbuf_valid_q & (wbuf_cnt_q == DRAIN_CNT);
        req_ready  = (state_q == IDLE) & (~wbuf_valid_q | wbuf_hit);
        wbuf_push  = req_valid_i & req_ready & req_we_i & ~wbuf_valid_q;
        fwd_rd     = req_valid_i & req_ready & wbuf_valid_q;
        fsm_accept = req_valid_i & req_ready & ~req_we_i & ~wbuf_valid_q;
        if (wbuf_drain) begin
            ram_we    = 1'b1;
            ram_waddr = wbuf_addr_q;
            ram_wdata = wbuf_data_q;
        end
        rsp_valid_d = rsp_valid_d | wbuf_push | fwd_rd;
        if (wbuf_push) begin
            rsp_is_write_d = 1'b1;
        end else if (fwd_rd) begin
            rsp_is_write_d = 1'b0;
        end
`endif
    end

`ifdef DMEM_WBUF_EN
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wbuf_valid_q <= 1'b0;
            wbuf_cnt_q   <= '0;
            wbuf_addr_q  <= '0;
            wbuf_data_q  <= '0;
        end else if (wbuf_push) begin
            wbuf_valid_q <= 1'b1;
            wbuf_cnt_q   <= 3'd0;
            wbuf_addr_q  <= req_addr_i;
            wbuf_data_q  <= req_wdata_i;
        end else if (wbuf_drain) begin
            wbuf_valid_q <= 1'b0;
        end else if (wbuf_valid_q) begin
            wbuf_cnt_q <= wbuf_cnt_q + 3'd1;
        end
    end
`endif

    // RAM has no reset so it maps onto block memory; writes are gated by reset-cleared state.
    always_ff @(posedge clock_i) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    assign req_ready_o    = req_ready;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_is_write_o = rsp_is_write_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign stall_o        = req_valid_i & ~req_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two instances (WAIT_STATES=1 and 0); directed requests push expected
// responses into per-instance queues and a negedge monitor pops and compares them.
module tb_dmem_responder;
`ifdef DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif
    localparam int LAT1 = 2;
    localparam int ST1  = WBUF ? 1 : 2;
    localparam int LDF1 = WBUF ? 1 : 2;

    typedef struct {
        logic        is_write;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic [1:0]       rst_n = 2'b00;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_we = 2'b00;
    logic [1:0][11:0] req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_is_write;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       stall;

    exp_t             q0[$];
    exp_t             q1[$];
    logic [1:0][31:0] last_rd = '0;
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(12), .DATA_W(32), .WAIT_STATES(0)) u_dut0 (
        .clock_i(clk), .resetn_i(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .req_ready_o(req_ready[0]), .rsp_valid_o(rsp_valid[0]),
        .rsp_is_write_o(rsp_is_write[0]), .rsp_rdata_o(rsp_rdata[0]),
        .stall_o(stall[0])
    );

    dmem_responder #(.ADDR_W(12), .DATA_W(32), .WAIT_STATES(1)) u_dut1 (
        .clock_i(clk), .resetn_i(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .req_ready_o(req_ready[1]), .rsp_valid_o(rsp_valid[1]),
        .rsp_is_write_o(rsp_is_write[1]), .rsp_rdata_o(rsp_rdata[1]),
        .stall_o(stall[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input bit idx, input exp_t e);
        $display("rsp dut%0d cyc=%0d is_write=%0b rdata=0x%08h", idx, cyc, rsp_is_write[idx], rsp_rdata[idx]);
        chk($sformatf("dut%0d_rsp_is_write", idx), 32'(rsp_is_write[idx]), 32'(e.is_write));
        chk($sformatf("dut%0d_rsp_rdata", idx), rsp_rdata[idx], e.rdata);
        chk($sformatf("dut%0d_rsp_cycle", idx), cyc, e.cyc);
    endtask

    task automatic unexpected(input bit idx);
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_rsp: rsp_valid=1 at cyc=%0d, required 0 (nothing outstanding)", idx, cyc);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) begin
                if (q0.size() == 0) unexpected(1'b0);
                else check_rsp(1'b0, q0.pop_front());
            end
            if (rsp_valid[1] === 1'b1) begin
                if (q1.size() == 0) unexpected(1'b1);
                else check_rsp(1'b1, q1.pop_front());
            end
        end
    end

    task automatic chk_reset(input bit idx, input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready[idx]), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid[idx]), 32'd0);
        chk({tag, "_rsp_is_write"}, 32'(rsp_is_write[idx]), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata[idx], 32'd0);
        chk({tag, "_stall"}, 32'(stall[idx]), 32'd0);
    endtask

    // Present one request, wait (bounded) for acceptance, push its expected response.
    // gap > 0 keeps req_valid low and drives inverted garbage on the inputs for gap cycles.
    task automatic issue(input bit idx, input logic we, input logic [11:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rd, input int lat,
                         input bit push, input int gap, output int acc, output int stalls);
        exp_t e;
        int   waited;
        waited = 0;
        stalls = 0;
        acc    = 0;
        req_valid[idx] = 1'b1;
        req_we[idx]    = we;
        req_addr[idx]  = addr;
        req_wdata[idx] = data;
        @(negedge clk);
        while (req_ready[idx] !== 1'b1 && waited < 40) begin
            if (stall[idx] === 1'b1) stalls++;
            waited++;
            @(negedge clk);
        end
        if (waited >= 40) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_accept_timeout: req_ready=0 for %0d cycles, required acceptance", idx, waited);
            req_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        $display("req dut%0d %s addr=0x%03h wdata=0x%08h accepted cyc=%0d stalls=%0d",
                 idx, we ? "sw" : "lw", addr, data, acc, stalls);
        if (push) begin
            e.is_write = we;
            e.cyc      = acc + lat;
            if (we) begin
                e.rdata = last_rd[idx];
            end else begin
                e.rdata      = exp_rd;
                last_rd[idx] = exp_rd;
            end
            if (idx) q1.push_back(e);
            else q0.push_back(e);
        end
        req_valid[idx] = 1'b0;
        if (gap > 0) begin
            req_we[idx]    = ~we;
            req_addr[idx]  = ~addr;
            req_wdata[idx] = ~data;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1, a2, s1, s2;
        repeat (3) @(posedge clk);
        #1;
        chk_reset(1'b0, "por0");
        chk_reset(1'b1, "por1");
        @(negedge clk);
        rst_n = 2'b11;
        @(posedge clk);
        #1;

        // Store then load of the same word.
        issue(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0, ST1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, LDF1, 1'b1, 0, a1, s1);

        // Back-to-back loads with req_valid held high.
        issue(1'b1, 1'b1, 12'h001, 32'h00000101, 32'h0, ST1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b1, 12'h002, 32'h00000202, 32'h0, ST1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b0, 12'h001, 32'h0, 32'h00000101, LAT1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b0, 12'h002, 32'h0, 32'h00000202, LAT1, 1'b1, 0, a2, s2);
        chk("ws1_b2b_accept_gap", a2 - a1, 32'd3);
        chk("ws1_b2b_stall_cycles", s2, 32'd2);

        // Zero wait states, top address.
        issue(1'b0, 1'b1, 12'hFFF, 32'h12345678, 32'h0, 1, 1'b1, 0, a1, s1);
        issue(1'b0, 1'b0, 12'hFFF, 32'h0, 32'h12345678, 1, 1'b1, 0, a1, s1);
        issue(1'b0, 1'b1, 12'h000, 32'h0000ABCD, 32'h0, 1, 1'b1, 0, a1, s1);
        issue(1'b0, 1'b0, 12'hFFF, 32'h0, 32'h12345678, 1, 1'b1, 0, a1, s1);
        issue(1'b0, 1'b0, 12'h000, 32'h0, 32'h0000ABCD, 1, 1'b1, 0, a2, s2);
        chk("ws0_b2b_accept_gap", a2 - a1, 32'd2);
        chk("ws0_b2b_stall_cycles", s2, 32'd1);

        // Inputs change after accept; latched values must be used.
        issue(1'b1, 1'b1, 12'h041, 32'h41414141, 32'h0, ST1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b1, 12'h040, 32'h0BADF00D, 32'h0, ST1, 1'b1, 4, a1, s1);
        issue(1'b1, 1'b0, 12'h040, 32'h0, 32'h0BADF00D, LAT1, 1'b1, 1, a1, s1);
        issue(1'b1, 1'b0, 12'h041, 32'h0, 32'h41414141, LAT1, 1'b1, 0, a1, s1);

        // Reset while a store is in flight: no response, RAM keeps old word.
        issue(1'b1, 1'b1, 12'h030, 32'h11111111, 32'h0, ST1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b0, 12'h030, 32'h0, 32'h11111111, LDF1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b1, 12'h031, 32'h22222222, 32'h0, ST1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b1, 12'h030, 32'hCAFEF00D, 32'h0, ST1, 1'b0, 0, a1, s1);
        rst_n[1] = 1'b0;
        #2;
        chk_reset(1'b1, "mid_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n[1]   = 1'b1;
        last_rd[1] = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 12'h030, 32'h0, 32'h11111111, LAT1, 1'b1, 0, a1, s1);

`ifdef DMEM_WBUF_EN
        // Posted store with forwarded load, then a non-matching load stalled by the drain.
        issue(1'b1, 1'b1, 12'h021, 32'h21212121, 32'h0, 1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b1, 12'h020, 32'hA5A5A5A5, 32'h0, 1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b0, 12'h020, 32'h0, 32'hA5A5A5A5, 1, 1'b1, 0, a2, s2);
        chk("wbuf_fwd_accept_gap", a2 - a1, 32'd1);
        issue(1'b1, 1'b1, 12'h022, 32'h5A5A5A5A, 32'h0, 1, 1'b1, 0, a1, s1);
        issue(1'b1, 1'b0, 12'h021, 32'h0, 32'h21212121, LAT1, 1'b1, 0, a2, s2);
        chk("wbuf_miss_stall_cycles", s2, 32'd2);
`endif

        repeat (10) @(posedge clk);
        #1;
        chk("dut0_outstanding_rsp", q0.size(), 32'd0);
        chk("dut1_outstanding_rsp", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
